alu_mem_stage: RTL and testbench

ALU_MEM_STAGE -- requirements
Module: alu_mem_stage

---
 rtl/alu_mem_stage.sv | 138 +++++++++++++
 tb/tb_alu_mem_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mem_stage.sv
// alu_mem_stage: ALU-to-memory pipeline stage with a two-entry skid buffer.
// Memory lane alignment (byte enables, shifted store data, misalign flag) is
// computed at acceptance and registered with each entry.
//
// Ports:
//   clk, resetN            clock, asynchronous active-low reset
//   flush                  drop held and incoming entries
//   inValid / inReady      upstream handshake (inReady comes from a flop)
//   dataIn                 ALU result / memory address
//   storeDataIn            LSB-justified store data
//   memOpIn, memSizeIn     00 none / 01 load / 10 store / 11 none; size b/h/w/d
//   writeEnableIn, writeBackAddrIn   writeback control
//   outValid / outReady    downstream handshake
//   dataOut .. misalignOut registered, lane-aligned entry fields
module alu_mem_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  flush,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [DATA_W-1:0]     dataIn,
    input  logic [DATA_W-1:0]     storeDataIn,
    input  logic [1:0]            memOpIn,
    input  logic [1:0]            memSizeIn,
    input  logic                  writeEnableIn,
    input  logic [REG_ADDR_W-1:0] writeBackAddrIn,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_W-1:0]     dataOut,
    output logic [DATA_W-1:0]     storeDataOut,
    output logic [DATA_W/8-1:0]   byteEnOut,
    output logic [1:0]            memOpOut,
    output logic [1:0]            memSizeOut,
    output logic                  writeEnableOut,
    output logic [REG_ADDR_W-1:0] writeBackAddrOut,
    output logic                  misalignOut
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [DATA_W-1:0]     sdata;
        logic [BE_W-1:0]       be;
        logic [1:0]            op;
        logic [1:0]            size;
        logic                  we;
        logic [REG_ADDR_W-1:0] wba;
        logic                  mis;
    } entry_t;

    entry_t     in_entry, main_q, skid_q;
    logic       main_valid, skid_valid;
    logic       accept;
    logic [OFF_W-1:0] offset;

    // Alignment of the incoming entry.
    always_comb begin
        logic        is_mem;
        logic        size_mis;
        int unsigned off_u;
        int unsigned nbytes;

        offset = dataIn[OFF_W-1:0];
        off_u  = {{(32-OFF_W){1'b0}}, offset};
        nbytes = 32'd1 << memSizeIn;
        is_mem = (memOpIn == 2'b01) || (memOpIn == 2'b10);

        unique case (memSizeIn)
            2'b00:   size_mis = 1'b0;
            2'b01:   size_mis = offset[0];
            2'b10:   size_mis = |offset[1:0];
            default: size_mis = (DATA_W == 32) ? 1'b1 : |offset;
        endcase

        in_entry      = '0;
        in_entry.data = dataIn;
        in_entry.size = memSizeIn;
        in_entry.wba  = writeBackAddrIn;
        in_entry.mis  = is_mem && size_mis;
        in_entry.we   = writeEnableIn && !in_entry.mis;

        if (is_mem && !size_mis) begin
            in_entry.op = memOpIn;
            for (int unsigned i = 0; i < BE_W; i++)
                in_entry.be[i] = (i >= off_u) && (i < off_u + nbytes);
            if (memOpIn == 2'b10)
                in_entry.sdata = storeDataIn << {offset, 3'b000};
        end
    end

    assign inReady = !skid_valid;
    assign accept  = inValid && inReady;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // inReady is low here, so only the skid->main move can happen.
            if (outReady) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid || outReady) begin
                main_q     <= in_entry;
                main_valid <= 1'b1;
            end else begin
                skid_q     <= in_entry;
                skid_valid <= 1'b1;
            end
        end else if (outReady) begin
            main_valid <= 1'b0;
        end
    end

    assign outValid         = main_valid;
    assign dataOut          = main_q.data;
    assign storeDataOut     = main_q.sdata;
    assign byteEnOut        = main_q.be;
    assign memOpOut         = main_q.op;
    assign memSizeOut       = main_q.size;
    assign writeEnableOut   = main_q.we;
    assign writeBackAddrOut = main_q.wba;
    assign misalignOut      = main_q.mis;

endmodule

// File: tb/tb_alu_mem_stage.sv
// Self-checking bench for alu_mem_stage (DATA_W=32): alignment vector table,
// hand-written handshake/flush/reset sequences, randomized run vs queue model.
module tb_alu_mem_stage;

    logic        clk = 1'b0;
    logic        resetN, flush, inValid, inReady, outValid, outReady;
    logic [31:0] dataIn, storeDataIn, dataOut, storeDataOut;
    logic [1:0]  memOpIn, memSizeIn, memOpOut, memSizeOut;
    logic        writeEnableIn, writeEnableOut, misalignOut;
    logic [4:0]  writeBackAddrIn, writeBackAddrOut;
    logic [3:0]  byteEnOut;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_mem_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .resetN(resetN), .flush(flush),
        .inValid(inValid), .inReady(inReady),
        .dataIn(dataIn), .storeDataIn(storeDataIn),
        .memOpIn(memOpIn), .memSizeIn(memSizeIn),
        .writeEnableIn(writeEnableIn), .writeBackAddrIn(writeBackAddrIn),
        .outValid(outValid), .outReady(outReady),
        .dataOut(dataOut), .storeDataOut(storeDataOut), .byteEnOut(byteEnOut),
        .memOpOut(memOpOut), .memSizeOut(memSizeOut),
        .writeEnableOut(writeEnableOut), .writeBackAddrOut(writeBackAddrOut),
        .misalignOut(misalignOut)
    );

    typedef struct {
        logic [31:0] data, sdata;
        logic [3:0]  be;
        logic [1:0]  op, size;
        logic        we;
        logic [4:0]  wba;
        logic        mis;
    } pay_t;

    typedef struct {
        logic [31:0] addr, sd;
        logic [1:0]  op, size;
        logic        we;
        logic [4:0]  wba;
        logic [31:0] e_sdata;
        logic [3:0]  e_be;
        logic [1:0]  e_op;
        logic        e_we, e_mis;
    } vec_t;

    pay_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_pay(input string nm, input pay_t e);
        chk({nm, ".dataOut"},      64'(dataOut),          64'(e.data));
        chk({nm, ".storeDataOut"}, 64'(storeDataOut),     64'(e.sdata));
        chk({nm, ".byteEnOut"},    64'(byteEnOut),        64'(e.be));
        chk({nm, ".memOpOut"},     64'(memOpOut),         64'(e.op));
        chk({nm, ".memSizeOut"},   64'(memSizeOut),       64'(e.size));
        chk({nm, ".writeEnable"},  64'(writeEnableOut),   64'(e.we));
        chk({nm, ".wbAddr"},       64'(writeBackAddrOut), 64'(e.wba));
        chk({nm, ".misalign"},     64'(misalignOut),      64'(e.mis));
    endtask

    // Reference: derived from the access rules with plain arithmetic.
    function automatic pay_t model(input logic [31:0] addr, input logic [31:0] sd,
                                   input logic [1:0] op, input logic [1:0] size,
                                   input logic we, input logic [4:0] wba);
        pay_t p;
        int   off = int'(addr % 4);
        int   nb  = 1 << size;
        bit   mem = (op == 2'd1) || (op == 2'd2);
        p.data  = addr;
        p.size  = size;
        p.wba   = wba;
        p.mis   = mem && (size == 2'd3 || (off % nb) != 0);
        p.we    = p.mis ? 1'b0 : we;
        p.op    = 2'd0;
        p.be    = 4'd0;
        p.sdata = 32'd0;
        if (mem && !p.mis) begin
            p.op = op;
            p.be = 4'(((1 << nb) - 1) << off);
            if (op == 2'd2) p.sdata = 32'(64'(sd) * (64'd1 << (8 * off)));
        end
        return p;
    endfunction

    task automatic drive(input logic [31:0] addr, input logic [31:0] sd, input logic [1:0] op,
                         input logic [1:0] size, input logic we, input logic [4:0] wba, input logic iv);
        dataIn = addr; storeDataIn = sd; memOpIn = op; memSizeIn = size;
        writeEnableIn = we; writeBackAddrIn = wba; inValid = iv;
    endtask

    task automatic do_reset();
        resetN = 1'b0; flush = 1'b0; outReady = 1'b1;
        drive(32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // Leaves main=A, skid=B at a negedge with inValid=0, outReady=0.
    task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
        outReady = 1'b0;
        drive(a, 32'd0, 2'd0, 2'd2, 1'b1, 5'd1, 1'b1);
        @(negedge clk);
        drive(b, 32'd0, 2'd0, 2'd2, 1'b1, 5'd2, 1'b1);
        @(negedge clk);
        inValid = 1'b0;
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{32'h1003, 32'hAB,       2'd2, 2'd0, 1'b0, 5'd3,  32'hAB000000, 4'b1000, 2'd2, 1'b0, 1'b0};
        vecs[1]  = '{32'h1002, 32'h0,        2'd1, 2'd2, 1'b1, 5'd4,  32'h0,        4'b0000, 2'd0, 1'b0, 1'b1};
        vecs[2]  = '{32'h2002, 32'h1234,     2'd1, 2'd1, 1'b1, 5'd5,  32'h0,        4'b1100, 2'd1, 1'b1, 1'b0};
        vecs[3]  = '{32'h2001, 32'hBEEF,     2'd2, 2'd1, 1'b0, 5'd6,  32'h0,        4'b0000, 2'd0, 1'b0, 1'b1};
        vecs[4]  = '{32'h3000, 32'hDEADBEEF, 2'd2, 2'd2, 1'b0, 5'd7,  32'hDEADBEEF, 4'b1111, 2'd2, 1'b0, 1'b0};
        vecs[5]  = '{32'h0005, 32'hFF,       2'd0, 2'd0, 1'b1, 5'd8,  32'h0,        4'b0000, 2'd0, 1'b1, 1'b0};
        vecs[6]  = '{32'h0007, 32'hFF,       2'd3, 2'd2, 1'b1, 5'd9,  32'h0,        4'b0000, 2'd0, 1'b1, 1'b0};
        vecs[7]  = '{32'h0004, 32'h55,       2'd2, 2'd3, 1'b0, 5'd10, 32'h0,        4'b0000, 2'd0, 1'b0, 1'b1};
        vecs[8]  = '{32'h0002, 32'h00CD,     2'd2, 2'd1, 1'b0, 5'd11, 32'h00CD0000, 4'b1100, 2'd2, 1'b0, 1'b0};
        vecs[9]  = '{32'h0001, 32'h1FF,      2'd2, 2'd0, 1'b0, 5'd12, 32'h0001FF00, 4'b0010, 2'd2, 1'b0, 1'b0};
        vecs[10] = '{32'h1002, 32'h77,       2'd1, 2'd0, 1'b1, 5'd13, 32'h0,        4'b0100, 2'd1, 1'b1, 1'b0};

        // Reset state
        do_reset();
        resetN = 1'b0;
        #1;
        chk("reset.outValid", 64'(outValid), 64'd0);
        chk("reset.inReady",  64'(inReady),  64'd1);
        chk("reset.payload", {dataOut, storeDataOut} | 64'({byteEnOut, memOpOut, memSizeOut,
            writeEnableOut, writeBackAddrOut, misalignOut}), 64'd0);
        @(negedge clk);
        resetN = 1'b1;

        // Alignment table
        foreach (vecs[i]) begin
            pay_t e;
            drive(vecs[i].addr, vecs[i].sd, vecs[i].op, vecs[i].size, vecs[i].we, vecs[i].wba, 1'b1);
            @(negedge clk);
            inValid = 1'b0;
            e = '{vecs[i].addr, vecs[i].e_sdata, vecs[i].e_be, vecs[i].e_op, vecs[i].size,
                  vecs[i].e_we, vecs[i].wba, vecs[i].e_mis};
            chk($sformatf("vec%0d.outValid", i), 64'(outValid), 64'd1);
            chk_pay($sformatf("vec%0d", i), e);
        end
        @(negedge clk);

        // Streaming
        for (int i = 0; i < 3; i++) begin
            drive(32'h10 + 32'(4 * i), 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b1);
            @(negedge clk);
            chk($sformatf("stream%0d.data", i), 64'(dataOut), 64'(32'h10 + 32'(4 * i)));
            chk($sformatf("stream%0d.valid", i), 64'(outValid), 64'd1);
            chk($sformatf("stream%0d.ready", i), 64'(inReady), 64'd1);
        end
        inValid = 1'b0;
        @(negedge clk);
        chk("stream.drained", 64'(outValid), 64'd0);

        // Stall then release, order preserved
        fill_two(32'hA0, 32'hB0);
        chk("stall.ready", 64'(inReady), 64'd0);
        chk("stall.dataA", 64'(dataOut), 64'hA0);
        @(negedge clk);
        chk("stall.hold",  64'(dataOut), 64'hA0);
        outReady = 1'b1;
        drive(32'hC0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b1); // must not be taken
        @(negedge clk);
        inValid = 1'b0;
        chk("stall.dataB",   64'(dataOut),  64'hB0);
        chk("stall.readyup", 64'(inReady),  64'd1);
        @(negedge clk);
        chk("stall.empty",   64'(outValid), 64'd0);

        // Flush with both entries held and input presented
        fill_two(32'hA1, 32'hB1);
        flush = 1'b1;
        drive(32'hC1, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        chk("flush.valid", 64'(outValid), 64'd0);
        chk("flush.ready", 64'(inReady),  64'd1);
        @(negedge clk);
        chk("flush.gone",  64'(outValid), 64'd0);

        // Asynchronous reset mid-stall
        fill_two(32'hA2, 32'hB2);
        #2 resetN = 1'b0;
        #1;
        chk("areset.valid", 64'(outValid), 64'd0);
        chk("areset.ready", 64'(inReady),  64'd1);
        chk("areset.data",  64'(dataOut),  64'd0);
        chk("areset.be",    64'({byteEnOut, writeEnableOut, misalignOut}), 64'd0);
        @(negedge clk);
        resetN = 1'b1; outReady = 1'b1;
        drive(32'h44, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        inValid = 1'b0;
        chk("areset.after", 64'(dataOut), 64'h44);
        @(negedge clk);
        chk("areset.nodup", 64'(outValid), 64'd0);

        // Randomized run against queue model
        do_reset();
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit rdy;
            @(negedge clk);
            chk("rnd.outValid", 64'(outValid), 64'(q.size() > 0));
            chk("rnd.inReady",  64'(inReady),  64'(q.size() < 2));
            if (q.size() > 0) chk_pay($sformatf("rnd%0d", cyc), q[0]);
            drive($urandom, $urandom_range(0, 32'hFFFF), 2'($urandom), 2'($urandom),
                  1'($urandom), 5'($urandom), $urandom_range(0, 9) < 7);
            outReady = $urandom_range(0, 9) < 6;
            flush    = $urandom_range(0, 19) == 0;
            if (flush) q.delete();
            else begin
                rdy = q.size() < 2;
                if (q.size() > 0 && outReady) void'(q.pop_front());
                if (rdy && inValid)
                    q.push_back(model(dataIn, storeDataIn, memOpIn, memSizeIn,
                                      writeEnableIn, writeBackAddrIn));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
